// File: rtl/buzz_pkg.sv
// Shared types and helpers for the keypad-lock buzzer sequencer.
package buzz_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned REP_W = 4;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_CLICK = 2'd1,
    SRC_OK    = 2'd2,
    SRC_FAIL  = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Arbitration rank of a requester; higher wins.
  function automatic logic [1:0] prio(input src_t s);
    case (s)
      SRC_FAIL:  return 2'd3;
      SRC_OK:    return 2'd2;
      SRC_CLICK: return 2'd1;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_sequencer_if.sv
// Request/status bundle between the code-lock controller and the buzzer sequencer.
// The mute input exists only when BUZZER_MUTE_EN is defined.
interface buzzer_sequencer_if;
  import buzz_pkg::*;

  logic req_click;
  logic req_ok;
  logic req_fail;
`ifdef BUZZER_MUTE_EN
  logic mute;
`endif
  logic buzzer;
  logic busy;
  src_t active_src;
  logic done;

`ifdef BUZZER_MUTE_EN
  modport master (output req_click, req_ok, req_fail, mute,
                  input  buzzer, busy, active_src, done);
  modport slave  (input  req_click, req_ok, req_fail, mute,
                  output buzzer, busy, active_src, done);
`else
  modport master (output req_click, req_ok, req_fail,
                  input  buzzer, busy, active_src, done);
  modport slave  (input  req_click, req_ok, req_fail,
                  output buzzer, busy, active_src, done);
`endif

endinterface

// File: rtl/buzz_tone_gen.sv
// Square-wave generator: starts high on restart, toggles every `half` cycles while enabled.
module buzz_tone_gen
  import buzz_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] half,
  output logic             wave
);

  logic [CNT_W-1:0] half_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wave     <= 1'b0;
      half_cnt <= '0;
    end else if (restart) begin
      wave     <= 1'b1;
      half_cnt <= '0;
    end else if (en) begin
      if (half_cnt == half - CNT_W'(1)) begin
        wave     <= ~wave;
        half_cnt <= '0;
      end else begin
        half_cnt <= half_cnt + CNT_W'(1);
      end
    end else begin
      wave     <= 1'b0;
      half_cnt <= '0;
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Arbitrates click/accept/reject tone patterns onto the single buzzer pin.
// Define BUZZER_MUTE_EN to add a mute input that silences the pin without affecting sequencing.
module buzzer_sequencer
  import buzz_pkg::*;
#(
  parameter int unsigned CLICK_HALF = 50000,
  parameter int unsigned CLICK_LEN  = 10000000,
  parameter int unsigned OK_HALF    = 25000,
  parameter int unsigned OK_LEN     = 30000000,
  parameter int unsigned FAIL_HALF  = 100000,
  parameter int unsigned FAIL_ON    = 5000000,
  parameter int unsigned FAIL_GAP   = 5000000,
  parameter int unsigned FAIL_REPS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  buzzer_sequencer_if.slave bus
);

  state_t           state;
  src_t             src_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] len_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             wave;

  src_t             req_src_c;
  logic [CNT_W-1:0] on_len_c;
  logic [CNT_W-1:0] half_c;
  logic             last_rep_c;
  logic             on_last_c;
  logic             finish_c;
  logic             gap_last_c;
  logic             accept_c;

  // Highest-priority request this cycle.
  always_comb begin
    req_src_c = SRC_NONE;
    if (bus.req_fail)       req_src_c = SRC_FAIL;
    else if (bus.req_ok)    req_src_c = SRC_OK;
    else if (bus.req_click) req_src_c = SRC_CLICK;
  end

  always_comb begin
    on_len_c = CNT_W'(FAIL_ON);
    half_c   = CNT_W'(FAIL_HALF);
    case (src_q)
      SRC_CLICK: begin
        on_len_c = CNT_W'(CLICK_LEN);
        half_c   = CNT_W'(CLICK_HALF);
      end
      SRC_OK: begin
        on_len_c = CNT_W'(OK_LEN);
        half_c   = CNT_W'(OK_HALF);
      end
      default: ;
    endcase
  end

  assign last_rep_c = (src_q != SRC_FAIL) || (rep_cnt == REP_W'(FAIL_REPS - 1));
  assign on_last_c  = (state == ST_TONE) && (len_cnt == on_len_c - CNT_W'(1));
  assign finish_c   = on_last_c && last_rep_c;
  assign gap_last_c = (state == ST_GAP) && (gap_cnt == CNT_W'(FAIL_GAP - 1));
  // A completing pattern no longer holds the pin, so any request may start next.
  assign accept_c   = (req_src_c != SRC_NONE) &&
                      (prio(req_src_c) >= (finish_c ? 2'd0 : prio(src_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      src_q   <= SRC_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_cnt <= '0;
      gap_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      done_q <= finish_c;
      if (accept_c) begin
        state   <= ST_TONE;
        src_q   <= req_src_c;
        busy_q  <= 1'b1;
        len_cnt <= '0;
        gap_cnt <= '0;
        rep_cnt <= '0;
      end else begin
        case (state)
          ST_TONE: begin
            if (on_last_c) begin
              len_cnt <= '0;
              if (last_rep_c) begin
                state   <= ST_IDLE;
                src_q   <= SRC_NONE;
                busy_q  <= 1'b0;
                rep_cnt <= '0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end
            end else begin
              len_cnt <= len_cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_last_c) begin
              state   <= ST_TONE;
              gap_cnt <= '0;
              rep_cnt <= rep_cnt + REP_W'(1);
            end else begin
              gap_cnt <= gap_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  buzz_tone_gen u_tone (
    .clk     (clk),
    .rst     (rst),
    .en      ((state == ST_TONE) && !on_last_c),
    .restart (accept_c || gap_last_c),
    .half    (half_c),
    .wave    (wave)
  );

  assign bus.busy       = busy_q;
  assign bus.active_src = src_q;
  assign bus.done       = done_q;
`ifdef BUZZER_MUTE_EN
  assign bus.buzzer     = wave & ~bus.mute;
`else
  assign bus.buzzer     = wave;
`endif

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed and randomized checks of buzzer_sequencer against a timeline-based reference model.
module tb_buzzer_sequencer;
  import buzz_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  buzzer_sequencer_if bus ();

  int total = 0;
  int bad   = 0;
  bit mute_v = 1'b0;

  // Reference model state: playing source and position within its pattern timeline.
  int m_src  = 0;
  int m_pos  = 0;
  bit m_play = 1'b0;
  bit m_done = 1'b0;

  int busy_cnt, done_cnt, fail_src_cnt;
  int wave_bits;

  buzzer_sequencer #(
    .CLICK_HALF(2), .CLICK_LEN(10), .OK_HALF(1), .OK_LEN(8),
    .FAIL_HALF(3), .FAIL_ON(6), .FAIL_GAP(4), .FAIL_REPS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int p_on(input int s);
    return (s == 1) ? 10 : (s == 2) ? 8 : 6;
  endfunction
  function automatic int p_half(input int s);
    return (s == 1) ? 2 : (s == 2) ? 1 : 3;
  endfunction
  function automatic int p_gap(input int s);
    return (s == 3) ? 4 : 0;
  endfunction
  function automatic int p_reps(input int s);
    return (s == 3) ? 2 : 1;
  endfunction
  function automatic int p_total(input int s);
    return p_reps(s) * p_on(s) + (p_reps(s) - 1) * p_gap(s);
  endfunction
  function automatic int p_tone(input int s, input int pos);
    int r;
    r = pos % (p_on(s) + p_gap(s));
    if (r >= p_on(s)) return 0;
    return ((r / p_half(s)) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input bit c, input bit o, input bit f, input bit r);
    int req;
    if (r) begin
      m_src = 0; m_pos = 0; m_play = 1'b0; m_done = 1'b0;
    end else begin
      m_done = m_play && (m_pos == p_total(m_src) - 1);
      if (m_play) begin
        m_pos++;
        if (m_pos == p_total(m_src)) begin
          m_play = 1'b0; m_src = 0; m_pos = 0;
        end
      end
      req = f ? 3 : o ? 2 : c ? 1 : 0;
      if (req != 0 && req >= m_src) begin
        m_src = req; m_pos = 0; m_play = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit c, input bit o, input bit f, input bit r);
    int exp_buz;
    bus.req_click = c;
    bus.req_ok    = o;
    bus.req_fail  = f;
    rst           = r;
`ifdef BUZZER_MUTE_EN
    bus.mute      = mute_v;
`endif
    @(posedge clk);
    model_step(c, o, f, r);
    #1;
    bus.req_click = 1'b0;
    bus.req_ok    = 1'b0;
    bus.req_fail  = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    exp_buz = m_play ? p_tone(m_src, m_pos) : 0;
`ifdef BUZZER_MUTE_EN
    if (mute_v) exp_buz = 0;
`endif
    chk("buzzer", int'(bus.buzzer), exp_buz);
    chk("busy", int'(bus.busy), int'(m_play));
    chk("active_src", int'(bus.active_src), m_src);
    chk("done", int'(bus.done), int'(m_done));
    busy_cnt     += int'(bus.busy);
    done_cnt     += int'(bus.done);
    fail_src_cnt += (int'(bus.active_src) == 3) ? 1 : 0;
    wave_bits     = (wave_bits << 1) | int'(bus.buzzer);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr();
    busy_cnt = 0; done_cnt = 0; fail_src_cnt = 0; wave_bits = 0;
  endtask

  initial begin
    bus.req_click = 1'b0;
    bus.req_ok    = 1'b0;
    bus.req_fail  = 1'b0;
`ifdef BUZZER_MUTE_EN
    bus.mute      = 1'b0;
`endif
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_src", int'(bus.active_src), 0);
    chk("rst_buzzer", int'(bus.buzzer), 0);

    // Single click: fixed waveform, 10 busy cycles, one done.
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    chk("c1_wave", wave_bits & 10'h3ff, 10'b1100110011);
    idle(4);
    chk("c1_busy_len", busy_cnt, 10);
    chk("c1_done_cnt", done_cnt, 1);

    // Reject: two bursts with a gap, 16 busy cycles attributed to fail.
    clr();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("c2_busy_len", busy_cnt, 16);
    chk("c2_src_len", fail_src_cnt, 16);
    chk("c2_done_cnt", done_cnt, 1);

    // Accept preempts click three cycles in.
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("c3_src_ok", int'(bus.active_src), 2);
    chk("c3_buz_restart", int'(bus.buzzer), 1);
    idle(12);
    chk("c3_busy_len", busy_cnt, 11);
    chk("c3_done_cnt", done_cnt, 1);

    // Lower-priority requests during reject are dropped.
    clr();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(14);
    chk("c4_busy_len", busy_cnt, 16);
    chk("c4_done_cnt", done_cnt, 1);

    // Simultaneous requests: fail wins.
    clr();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("c5_src", int'(bus.active_src), 3);
    idle(19);
    chk("c5_src_len", fail_src_cnt, 16);
    chk("c5_done_cnt", done_cnt, 1);

    // Reset mid accept tone: immediate silence, no done.
    clr();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c6_busy", int'(bus.busy), 0);
    chk("c6_src", int'(bus.active_src), 0);
    idle(10);
    chk("c6_done_cnt", done_cnt, 0);

    // Completion and a new request in the same cycle.
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    chk("c7_busy_len", busy_cnt, 20);
    chk("c7_done_cnt", done_cnt, 2);

`ifdef BUZZER_MUTE_EN
    clr();
    mute_v = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    chk("m_wave", wave_bits, 0);
    chk("m_busy_len", busy_cnt, 10);
    chk("m_done_cnt", done_cnt, 1);
    mute_v = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
`ifdef BUZZER_MUTE_EN
      if ($urandom_range(0, 49) == 0) mute_v = ~mute_v;
`endif
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
